// File: rtl/data_memory_rmw_pkg.sv
// dmem_pkg: shared types and helpers for the data memory.
//   funct3_t     : RISC-V load/store size/sign codes
//   dmem_state_t : RMW sequencer state
//   misaligned() : rejects accesses that do not fit the addressed size
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_LB   = 3'b000,
    F3_LH   = 3'b001,
    F3_LW   = 3'b010,
    F3_LD   = 3'b011,
    F3_LBU  = 3'b100,
    F3_LHU  = 3'b101,
    F3_LWU  = 3'b110,
    F3_RSVD = 3'b111
  } funct3_t;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } dmem_state_t;

  // lane is the byte offset within the word, zero-extended to 3 bits.
  // is_dw says the word is 64 bits wide, which is what makes LD/LWU legal.
  function automatic logic misaligned(input logic [2:0] f3,
                                      input logic [2:0] lane,
                                      input logic       is_dw);
    logic bad;
    case (f3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = lane[0];
      F3_LW:         bad = (lane[1:0] != 2'b00);
      F3_LWU:        bad = !is_dw || (lane[1:0] != 2'b00);
      F3_LD:         bad = !is_dw || (lane != 3'b000);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_memory_rmw_if.sv
// data_memory_rmw_if: MEM-stage request/response bundle for the data memory.
//   master (MEM stage) drives: MemRead, MemWrite, Funct3, a, wd
//   slave  (memory)    drives: ready, rd, rd_valid, misalign, state
// Handshake: a request is valid while MemRead or MemWrite is high and is
// consumed at the rising edge where ready is also high; the master must hold
// the request unchanged while ready is low. rd_valid and misalign are
// single-cycle responses with no back-pressure. state is a debug view of the
// RMW sequencer.
interface data_memory_rmw_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) ();
  import dmem_pkg::*;

  localparam int BYTE_OFF = $clog2(DATA_W / 8);

  logic                           MemRead;
  logic                           MemWrite;
  logic [2:0]                     Funct3;
  logic [DM_ADDRESS+BYTE_OFF-1:0] a;
  logic [DATA_W-1:0]              wd;
  logic                           ready;
  logic [DATA_W-1:0]              rd;
  logic                           rd_valid;
  logic                           misalign;
  dmem_state_t                    state;

  modport master (
    output MemRead, MemWrite, Funct3, a, wd,
    input  ready, rd, rd_valid, misalign, state
  );

  modport slave (
    input  MemRead, MemWrite, Funct3, a, wd,
    output ready, rd, rd_valid, misalign, state
  );

endinterface

// File: rtl/data_memory_rmw_lane_unit.sv
// dmem_lane_unit: combinational byte-lane logic for the data memory.
//   ld_word/ld_lane/ld_funct3 -> ld_data   : load extract + sign/zero extend
//   st_word/st_data/st_lane/st_size -> st_merged : sub-word store byte merge
// st_size is Funct3[1:0] (0=byte, 1=half, 2=word, 3=double).
module dmem_lane_unit
  import dmem_pkg::*;
#(
  parameter  int DATA_W   = 32,
  localparam int BYTE_OFF = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0]   ld_word,
  input  logic [BYTE_OFF-1:0] ld_lane,
  input  logic [2:0]          ld_funct3,
  output logic [DATA_W-1:0]   ld_data,
  input  logic [DATA_W-1:0]   st_word,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [BYTE_OFF-1:0] st_lane,
  input  logic [1:0]          st_size,
  output logic [DATA_W-1:0]   st_merged
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;

  // Loads: bring the addressed lane down to bit 0, then extend.
  // Signed casts sign-extend, unsigned casts zero-extend.
  always_comb begin
    shifted = ld_word >> {ld_lane, 3'b000};
    case (ld_funct3)
      F3_LB:   ld_data = DATA_W'($signed(shifted[7:0]));
      F3_LH:   ld_data = DATA_W'($signed(shifted[15:0]));
      F3_LW:   ld_data = DATA_W'($signed(shifted[31:0]));
      F3_LBU:  ld_data = DATA_W'(shifted[7:0]);
      F3_LHU:  ld_data = DATA_W'(shifted[15:0]);
      F3_LWU:  ld_data = DATA_W'(shifted[31:0]);
      F3_LD:   ld_data = shifted;
      default: ld_data = '0;
    endcase
  end

  // Stores: the low bytes of st_data replace the addressed lane only.
  always_comb begin
    case (st_size)
      2'b00:   mask = DATA_W'(8'hFF);
      2'b01:   mask = DATA_W'(16'hFFFF);
      2'b10:   mask = DATA_W'(32'hFFFF_FFFF);
      default: mask = '1;
    endcase
    st_merged = (st_word & ~(mask << {st_lane, 3'b000}))
              | ((st_data & mask) << {st_lane, 3'b000});
  end

endmodule

// File: rtl/data_memory_rmw.sv
// data_memory_rmw: byte-addressed data memory for the MEM stage.
// Word-wide storage; sub-word stores go through a 2-cycle read-modify-write.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : data_memory_rmw_if.slave (request in, ready/rd/rd_valid/
//                misalign/state out)
//   perf_loads, perf_stores, perf_stalls : 32-bit saturating counters, only
//                present when DMEM_PERF_EN is defined
// Configuration macro: DMEM_PERF_EN
module data_memory_rmw
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  data_memory_rmw_if.slave  bus
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int   BYTE_OFF = $clog2(DATA_W / 8);
  localparam int   AW       = DM_ADDRESS + BYTE_OFF;
  localparam int   DEPTH    = 1 << DM_ADDRESS;
  localparam logic IS_DW    = (DATA_W == 64);

  logic [DATA_W-1:0] mem [DEPTH];

  dmem_state_t state, state_next;

  logic [DM_ADDRESS-1:0] idx;
  logic [BYTE_OFF-1:0]   lane;
  logic                  accept;
  logic                  reject;
  logic                  do_load;
  logic                  do_store;
  logic                  full_word;

  // Captured at the accept edge of a sub-word store.
  logic [DATA_W-1:0]     merge_q;
  logic [DATA_W-1:0]     wd_q;
  logic [DM_ADDRESS-1:0] idx_q;
  logic [BYTE_OFF-1:0]   lane_q;
  logic [1:0]            size_q;

  logic [DATA_W-1:0]     ld_data;
  logic [DATA_W-1:0]     st_merged;

  logic                  mem_we;
  logic [DM_ADDRESS-1:0] waddr;
  logic [DATA_W-1:0]     wdata;

  logic [DATA_W-1:0]     rd_q;
  logic                  rd_valid_q;
  logic                  misalign_q;

  assign idx  = bus.a[AW-1:BYTE_OFF];
  assign lane = bus.a[BYTE_OFF-1:0];

  // Ready depends on state alone so accept never loops back into it.
  assign bus.ready = (state == IDLE);
  assign accept    = (bus.MemRead || bus.MemWrite) && bus.ready;

  // Stores only have the four unsigned-less size codes; Funct3[2] set on a
  // store has no meaning, so it is rejected like a reserved code.
  assign reject = (bus.MemRead && bus.MemWrite)
               || misaligned(bus.Funct3, 3'(lane), IS_DW)
               || (bus.MemWrite && bus.Funct3[2]);

  assign do_load   = accept && bus.MemRead  && !reject;
  assign do_store  = accept && bus.MemWrite && !reject;
  assign full_word = (bus.Funct3[1:0] == (IS_DW ? 2'b11 : 2'b10));

  dmem_lane_unit #(.DATA_W(DATA_W)) u_lane (
    .ld_word   (mem[idx]),
    .ld_lane   (lane),
    .ld_funct3 (bus.Funct3),
    .ld_data   (ld_data),
    .st_word   (merge_q),
    .st_data   (wd_q),
    .st_lane   (lane_q),
    .st_size   (size_q),
    .st_merged (st_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Single write port: full-word stores write at their accept edge in IDLE,
  // merged sub-word stores write from RMW_WR. The two never coincide.
  // A reset in RMW_WR forces IDLE immediately, so the merge is dropped.
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    waddr      = idx;
    wdata      = bus.wd;
    case (state)
      IDLE: begin
        if (do_store) begin
          if (full_word) mem_we     = 1'b1;
          else           state_next = RMW_WR;
        end
      end
      RMW_WR: begin
        mem_we     = 1'b1;
        waddr      = idx_q;
        wdata      = st_merged;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (do_store && !full_word) begin
      merge_q <= mem[idx];
      wd_q    <= bus.wd;
      idx_q   <= idx;
      lane_q  <= lane;
      size_q  <= bus.Funct3[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      rd_valid_q <= do_load;
      misalign_q <= accept && reject;
      if (do_load) rd_q <= ld_data;
    end
  end

  assign bus.rd       = rd_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.misalign = misalign_q;
  assign bus.state    = state;

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_stalls <= '0;
    end else begin
      if (do_load  && (perf_loads  != 32'hFFFF_FFFF)) perf_loads  <= perf_loads  + 32'd1;
      if (do_store && (perf_stores != 32'hFFFF_FFFF)) perf_stores <= perf_stores + 32'd1;
      if (!bus.ready && (perf_stalls != 32'hFFFF_FFFF)) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
